pla_stim_driver: RTL and testbench

- Sequential stimulus driver and response compactor for the combinational PLA benchmarks in the power-aware synthesis train set.
- Drives the 10-bit primary-input vector into a PLA netlist and captures its 12-bit output vector.
- Folds each captured response into a MISR signature and counts output-bit toggles, giving a cheap functional/activity fingerprint per run.
- Sits on the bench/FPGA side, at the opposite end of the PLA input/output interface.

---
 rtl/pla_stim_pkg.sv | 19 +
 rtl/pla_stim_misr.sv | 31 +++
 rtl/pla_stim_driver.sv | 154 +++++++++++++++
 tb/tb_pla_stim_driver.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/pla_stim_pkg.sv
// Shared types and defaults for the PLA stimulus driver / response compactor.
package pla_stim_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  localparam int IN_W_DEF  = 10;
  localparam int OUT_W_DEF = 12;

  localparam logic [9:0]  LFSR_POLY_DEF = 10'h240;
  localparam logic [11:0] MISR_POLY_DEF = 12'h829;

  function automatic logic [5:0] popcount(input logic [31:0] v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < 32; i++) c = c + {5'd0, v[i]};
    return c;
  endfunction

endpackage

// File: rtl/pla_stim_misr.sv
// Multiple-input signature register folding one PLA response per enabled cycle.
module pla_stim_misr
  import pla_stim_pkg::*;
#(
  parameter int               OUT_W     = OUT_W_DEF,
  parameter logic [OUT_W-1:0] MISR_POLY = MISR_POLY_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [OUT_W-1:0] i_resp,
  output logic [OUT_W-1:0] o_sig
);

  logic [OUT_W-1:0] r_sig;
  logic [OUT_W-1:0] w_sig_nxt;

  assign w_sig_nxt = {r_sig[OUT_W-2:0], 1'b0}
                   ^ (r_sig[OUT_W-1] ? MISR_POLY : '0)
                   ^ i_resp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_sig <= '0;
    else if (i_clr) r_sig <= '0;
    else if (i_en)  r_sig <= w_sig_nxt;
  end

  assign o_sig = r_sig;

endmodule

// File: rtl/pla_stim_driver.sv
// Drives counter/LFSR vectors into a PLA and compacts its responses into a MISR
// signature; toggle counting is built only when PLA_STIM_TOGGLE_CNT_EN is defined.
module pla_stim_driver
  import pla_stim_pkg::*;
#(
  parameter int               IN_W       = IN_W_DEF,
  parameter int               OUT_W      = OUT_W_DEF,
  parameter int               SAMPLE_LAT = 0,
  parameter logic [IN_W-1:0]  LFSR_POLY  = LFSR_POLY_DEF,
  parameter logic [OUT_W-1:0] MISR_POLY  = MISR_POLY_DEF,
  parameter logic [IN_W-1:0]  LFSR_SEED  = IN_W'(1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             mode,
  input  logic [IN_W-1:0]  vec_count,
  output logic [IN_W-1:0]  pla_in,
  input  logic [OUT_W-1:0] pla_out,
  output logic             busy,
  output logic             done,
  output logic [OUT_W-1:0] signature,
  output logic [15:0]      toggle_count
);

  localparam logic [IN_W-1:0] SEED_EFF  = (LFSR_SEED == '0) ? IN_W'(1) : LFSR_SEED;
  localparam logic [IN_W:0]   CNT_FULL  = {1'b1, {IN_W{1'b0}}};
  localparam logic [IN_W:0]   LFSR_FULL = CNT_FULL - (IN_W+1)'(1);

  state_e              r_state, w_nstate;
  logic                r_mode;
  logic [IN_W-1:0]     r_pla_in;
  logic [IN_W:0]       r_left;       // vectors still to apply after the current one
  logic [IN_W:0]       r_cap_left;   // captures still outstanding
  logic [SAMPLE_LAT:0] r_vld_pipe;
  logic [SAMPLE_LAT:0] w_vld_nxt;
  logic [IN_W:0]       w_n;
  logic [IN_W-1:0]     w_next_vec;
  logic                w_start, w_adv, w_cap, w_last_cap;

  assign w_start    = start && (r_state == IDLE || r_state == DONE);
  assign w_adv      = (r_state == RUN) && (r_left != '0);
  assign w_cap      = r_vld_pipe[SAMPLE_LAT];
  assign w_last_cap = w_cap && (r_cap_left == (IN_W+1)'(1));

  assign w_n = (vec_count != '0) ? {1'b0, vec_count} : (mode ? LFSR_FULL : CNT_FULL);

  assign w_next_vec = r_mode ? ((r_pla_in >> 1) ^ (r_pla_in[0] ? LFSR_POLY : '0))
                             : (r_pla_in + IN_W'(1));

  // Stage 0 marks a freshly applied vector; the top stage is its capture edge.
  if (SAMPLE_LAT == 0) begin : g_lat0
    assign w_vld_nxt = w_adv;
  end else begin : g_latn
    assign w_vld_nxt = {r_vld_pipe[SAMPLE_LAT-1:0], w_adv};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nstate;
  end

  always_comb begin
    w_nstate = r_state;
    if (abort) w_nstate = IDLE;
    else begin
      case (r_state)
        IDLE, DONE: if (start) w_nstate = RUN;
        RUN: begin
          if (w_last_cap)          w_nstate = DONE;
          else if (r_left == '0)   w_nstate = DRAIN;
        end
        DRAIN: if (w_last_cap) w_nstate = DONE;
        default: w_nstate = IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (r_state == RUN) || (r_state == DRAIN);
    done = (r_state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode     <= 1'b0;
      r_pla_in   <= '0;
      r_left     <= '0;
      r_cap_left <= '0;
      r_vld_pipe <= '0;
    end else if (abort) begin
      r_vld_pipe <= '0;
    end else if (w_start) begin
      r_mode     <= mode;
      r_pla_in   <= mode ? SEED_EFF : '0;
      r_left     <= w_n - (IN_W+1)'(1);
      r_cap_left <= w_n;
      r_vld_pipe <= (SAMPLE_LAT+1)'(1);
    end else begin
      r_vld_pipe <= w_vld_nxt;
      if (w_adv) begin
        r_pla_in <= w_next_vec;
        r_left   <= r_left - (IN_W+1)'(1);
      end
      if (w_cap) r_cap_left <= r_cap_left - (IN_W+1)'(1);
    end
  end

  assign pla_in = r_pla_in;

  pla_stim_misr #(
    .OUT_W     (OUT_W),
    .MISR_POLY (MISR_POLY)
  ) u_misr (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_start && !abort),
    .i_en   (w_cap && !abort),
    .i_resp (pla_out),
    .o_sig  (signature)
  );

`ifdef PLA_STIM_TOGGLE_CNT_EN
  logic [OUT_W-1:0] r_prev;
  logic             r_have_prev;
  logic [15:0]      r_tog;
  logic [16:0]      w_tog_sum;

  assign w_tog_sum = {1'b0, r_tog} + {11'd0, popcount(32'(r_prev ^ pla_out))};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev      <= '0;
      r_have_prev <= 1'b0;
      r_tog       <= '0;
    end else if (!abort) begin
      if (w_start) begin
        r_have_prev <= 1'b0;
        r_tog       <= '0;
      end else if (w_cap) begin
        r_prev      <= pla_out;
        r_have_prev <= 1'b1;
        if (r_have_prev) r_tog <= w_tog_sum[16] ? 16'hFFFF : w_tog_sum[15:0];
      end
    end
  end

  assign toggle_count = r_tog;
`else
  assign toggle_count = '0;
`endif

endmodule

// File: tb/tb_pla_stim_driver.sv
// Directed bench: two drivers (SAMPLE_LAT 0 and 3) with PLA outputs looped back as {2'b00, pla_in}.
module tb_pla_stim_driver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start0 = 1'b0, start3 = 1'b0, abort = 1'b0, mode = 1'b0;
  logic [9:0]  vec_count = '0;
  logic [9:0]  pla_in0, pla_in3;
  logic [11:0] pla_out0, pla_out3, sig0, sig3;
  logic        busy0, busy3, done0, done3;
  logic [15:0] tog0, tog3;

  int n_chk = 0;
  int n_pass = 0;

  assign pla_out0 = {2'b00, pla_in0};
  assign pla_out3 = {2'b00, pla_in3};

  always #5 clk = ~clk;

  pla_stim_driver #(.SAMPLE_LAT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort), .mode(mode),
    .vec_count(vec_count), .pla_in(pla_in0), .pla_out(pla_out0), .busy(busy0),
    .done(done0), .signature(sig0), .toggle_count(tog0)
  );

  pla_stim_driver #(.SAMPLE_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort), .mode(mode),
    .vec_count(vec_count), .pla_in(pla_in3), .pla_out(pla_out3), .busy(busy3),
    .done(done3), .signature(sig3), .toggle_count(tog3)
  );

  function automatic logic [31:0] exp_tog(input int n);
`ifdef PLA_STIM_TOGGLE_CNT_EN
    return 32'(n);
`else
    return 32'(n * 0);
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Counter mode, 4 vectors: sequence 0..3, done after edge k+4, sig 003, 4 toggles.
  task automatic run_counter4(input string tag);
    mode = 1'b0; vec_count = 10'd4; start0 = 1'b1;
    tick;
    start0 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk({tag, "_pla_in"}, pla_in0, i);
      chk({tag, "_busy"}, busy0, 1);
      chk({tag, "_done_early"}, done0, 0);
      tick;
    end
    chk({tag, "_done"}, done0, 1);
    chk({tag, "_busy_end"}, busy0, 0);
    chk({tag, "_sig"}, sig0, 12'h003);
    chk({tag, "_tog"}, tog0, exp_tog(4));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [9:0] lfsr_exp [0:2];
    bit         seen [0:1023];
    int         bc, distinct, zero_hits;

    lfsr_exp[0] = 10'h001; lfsr_exp[1] = 10'h240; lfsr_exp[2] = 10'h120;

    #12;
    chk("rst_pla_in", pla_in0, 0);
    chk("rst_busy",   busy0, 0);
    chk("rst_done",   done0, 0);
    chk("rst_sig",    sig0, 0);
    chk("rst_tog",    tog0, 0);
    rst_n = 1'b1;
    tick;

    run_counter4("cnt4");

    // Single LFSR vector: one capture of 001, no toggles, counters cleared from prior run.
    mode = 1'b1; vec_count = 10'd1; start0 = 1'b1;
    tick;
    start0 = 1'b0;
    chk("v1_pla_in", pla_in0, 10'h001);
    tick;
    chk("v1_done", done0, 1);
    chk("v1_sig",  sig0, 12'h001);
    chk("v1_tog",  tog0, 0);

    // LFSR, 3 vectors; a start pulse mid-run must be ignored.
    mode = 1'b1; vec_count = 10'd3; start0 = 1'b1;
    tick;
    start0 = 1'b0;
    bc = 0;
    for (int i = 0; i < 8; i++) begin
      if (i < 3) chk("l3_pla_in", pla_in0, lfsr_exp[i]);
      if (busy0) bc++;
      if (i == 0) begin start0 = 1'b1; mode = 1'b0; end
      tick;
      start0 = 1'b0;
    end
    chk("l3_busy_cycles", bc, 3);
    chk("l3_hold", pla_in0, 10'h120);
    chk("l3_done", done0, 1);

    // Full-period LFSR run.
    for (int i = 0; i < 1024; i++) seen[i] = 1'b0;
    distinct = 0; zero_hits = 0; bc = 0;
    mode = 1'b1; vec_count = 10'd0; start0 = 1'b1;
    tick;
    start0 = 1'b0;
    for (int i = 0; i < 2000 && busy0; i++) begin
      if (!seen[pla_in0]) begin seen[pla_in0] = 1'b1; distinct++; end
      if (pla_in0 == 10'h000) zero_hits++;
      bc++;
      tick;
    end
    chk("lf_timeout", busy0, 0);
    chk("lf_distinct", distinct, 1023);
    chk("lf_vectors", bc, 1023);
    chk("lf_zero", zero_hits, 0);
    chk("lf_last", pla_in0, 10'h002);
    chk("lf_done", done0, 1);

    // SAMPLE_LAT=3: captures on k+4 and k+5, both seeing held vector 1.
    mode = 1'b0; vec_count = 10'd2; start3 = 1'b1;
    tick;
    start3 = 1'b0;
    chk("lat3_v0", pla_in3, 0);
    tick;
    chk("lat3_v1", pla_in3, 1);
    tick; tick; tick;
    chk("lat3_done_k4", done3, 0);
    chk("lat3_busy_k4", busy3, 1);
    tick;
    chk("lat3_done_k5", done3, 1);
    chk("lat3_busy_k5", busy3, 0);
    chk("lat3_sig", sig3, 12'h003);

    // Abort at edge k+2 of a 10-vector run.
    mode = 1'b0; vec_count = 10'd10; start0 = 1'b1;
    tick;
    start0 = 1'b0;
    tick;
    chk("ab_pre", pla_in0, 1);
    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk("ab_busy", busy0, 0);
    chk("ab_done", done0, 0);
    chk("ab_hold", pla_in0, 1);
    tick; tick; tick;
    chk("ab_hold_late", pla_in0, 1);
    chk("ab_done_late", done0, 0);

    // Asynchronous reset mid-run, then a clean rerun.
    mode = 1'b0; vec_count = 10'd5; start0 = 1'b1;
    tick;
    start0 = 1'b0;
    tick; tick;
    chk("mr_pre_pla_in", pla_in0, 2);
    chk("mr_pre_sig", sig0, 12'h001);
    chk("mr_pre_tog", tog0, exp_tog(1));
    rst_n = 1'b0;
    #1;
    chk("mr_pla_in", pla_in0, 0);
    chk("mr_busy",   busy0, 0);
    chk("mr_done",   done0, 0);
    chk("mr_sig",    sig0, 0);
    chk("mr_tog",    tog0, 0);
    #2;
    rst_n = 1'b1;
    tick;
    run_counter4("rerun");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
